bus_resp_mux: RTL and testbench



---
 rtl/bus_resp_mux_if.sv | 39 +++
 rtl/bus_resp_mux.sv | 136 +++++++++++++
 tb/tb_bus_resp_mux.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_resp_mux_if.sv
// rtl/bus_resp_mux_if.sv - master request / slave response bundle for bus_resp_mux
//
// Signals:
//   m_valid, m_addr        master request (address bits [31:28] select the slave)
//   m_ready, m_rdata,      one-cycle completion pulse with read data and error flag
//   m_err
//   busy                   transaction outstanding
//   sN_ready, sN_rdata     response ports of slave 0 (memory), 1 (GPIO), 2 (I2C)
// Modports:
//   slave   the response mux side (consumes requests and slave responses)
//   master  the environment side (drives requests and slave responses)
interface bus_resp_mux_if #(
    parameter int DATA_W = 32
) ();
    logic              m_valid;
    logic [31:0]       m_addr;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;
    logic              busy;
    logic              s0_ready;
    logic [DATA_W-1:0] s0_rdata;
    logic              s1_ready;
    logic [DATA_W-1:0] s1_rdata;
    logic              s2_ready;
    logic [DATA_W-1:0] s2_rdata;

    modport slave (
        input  m_valid, m_addr,
        input  s0_ready, s0_rdata, s1_ready, s1_rdata, s2_ready, s2_rdata,
        output m_ready, m_rdata, m_err, busy
    );

    modport master (
        output m_valid, m_addr,
        output s0_ready, s0_rdata, s1_ready, s1_rdata, s2_ready, s2_rdata,
        input  m_ready, m_rdata, m_err, busy
    );
endinterface

// File: rtl/bus_resp_mux.sv
// rtl/bus_resp_mux.sv - return-path mux from three slaves to one master with timeout/unmapped error
//
// Parameters:
//   DATA_W    read-data width
//   TIMEOUT   BUSY cycles without the selected ready before an error response (1..65535)
//   ERR_DATA  read data returned with every error response
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       bus_resp_mux_if.slave: master request in, slave responses in,
//             registered m_ready/m_rdata/m_err/busy out
module bus_resp_mux #(
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_resp_mux_if.slave  bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_m_ready;
    logic [DATA_W-1:0] r_m_rdata;
    logic              r_m_err;
    logic              r_busy;

    logic [2:0]        w_sel;
    logic              w_sel_ready;
    logic [DATA_W-1:0] w_sel_rdata;
    logic              w_unused_addr;

    // Only the region nibble takes part in decoding.
    assign w_unused_addr = ^bus.m_addr[27:0];

    always_comb begin
        w_sel = 3'b000;
        case (bus.m_addr[31:28])
            4'h0:    w_sel = 3'b001;
            4'h4:    w_sel = 3'b010;
            4'h5:    w_sel = 3'b100;
            default: w_sel = 3'b000;
        endcase
    end

    // Ready and data from non-selected slaves are masked off here, so a
    // stray ready from another slave can never complete the transaction.
    always_comb begin
        w_sel_ready = |(r_sel & {bus.s2_ready, bus.s1_ready, bus.s0_ready});
        w_sel_rdata = '0;
        case (r_sel)
            3'b001:  w_sel_rdata = bus.s0_rdata;
            3'b010:  w_sel_rdata = bus.s1_rdata;
            3'b100:  w_sel_rdata = bus.s2_rdata;
            default: w_sel_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= 3'b000;
            r_cnt     <= '0;
            r_m_ready <= 1'b0;
            r_m_rdata <= '0;
            r_m_err   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_m_ready <= 1'b0;
                    if (bus.m_valid) begin
                        r_sel  <= w_sel;
                        r_busy <= 1'b1;
                        if (|w_sel) begin
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    // A ready arriving on the last allowed cycle wins over the timeout.
                    if (w_sel_ready) begin
                        r_m_rdata <= w_sel_rdata;
                        r_m_err   <= 1'b0;
                        r_m_ready <= 1'b1;
                        r_state   <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_m_rdata <= ERR_DATA;
                        r_m_err   <= 1'b1;
                        r_m_ready <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    r_m_rdata <= ERR_DATA;
                    r_m_err   <= 1'b1;
                    r_m_ready <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    r_m_ready <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_m_ready <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_ready = r_m_ready;
    assign bus.m_rdata = r_m_rdata;
    assign bus.m_err   = r_m_err;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_bus_resp_mux.sv
// tb/tb_bus_resp_mux.sv - scoreboard testbench for bus_resp_mux
module tb_bus_resp_mux;

    localparam int          DATA_W  = 32;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] ERRD    = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    bus_resp_mux_if #(.DATA_W(DATA_W)) bus ();

    bus_resp_mux #(
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERRD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.cyc  = c;
        sb.push_back(x);
    endtask

    task automatic issue(input logic [31:0] addr, output int n);
        bus.m_valid = 1'b1;
        bus.m_addr  = addr;
        n = cyc;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!bus.m_ready && n < 40) begin
            tick();
            n++;
        end
        if (!bus.m_ready) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no m_ready within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    // Monitor: every m_ready pulse is matched against the next expected response.
    always @(negedge clk) begin
        if (rst_n && bus.m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: m_ready=1 rdata=%0h err=%0b with no expected response (cycle %0d)",
                         bus.m_rdata, bus.m_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", 64'(bus.m_rdata), 64'(e.data));
                check("resp_err",   64'(bus.m_err),   64'(e.err));
                check("resp_cycle", 64'(cyc),         64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];
        logic        b2b_err  [4];

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.m_valid  = 1'b0;
        bus.m_addr   = '0;
        bus.s0_ready = 1'b0;
        bus.s0_rdata = '0;
        bus.s1_ready = 1'b0;
        bus.s1_rdata = '0;
        bus.s2_ready = 1'b0;
        bus.s2_rdata = '0;
        tick();
        tick();
        check("rst_m_ready", 64'(bus.m_ready), 64'd0);
        check("rst_m_err",   64'(bus.m_err),   64'd0);
        check("rst_m_rdata", 64'(bus.m_rdata), 64'd0);
        check("rst_busy",    64'(bus.busy),    64'd0);
        rst_n = 1'b1;
        tick();

        // Normal memory read, s0_ready three cycles after the request.
        issue(32'h0000_0010, n);
        push(32'hA5A5_1234, 1'b0, n + 4);
        tick();
        check("mem_busy_high", 64'(bus.busy), 64'd1);
        tick();
        tick();
        bus.s0_ready = 1'b1;
        bus.s0_rdata = 32'hA5A5_1234;
        tick();
        bus.s0_ready = 1'b0;
        bus.s0_rdata = 32'h0;
        wait_resp();
        tick();
        bus.m_valid = 1'b0;
        check("mem_busy_low", 64'(bus.busy), 64'd0);
        tick();

        // GPIO read; readies from the other slaves come first and must be ignored.
        bus.s1_rdata = 32'h0000_0BAD;
        issue(32'h4000_0000, n);
        push(32'h0000_00FF, 1'b0, n + 4);
        tick();
        bus.s0_ready = 1'b1;
        bus.s0_rdata = 32'h1111_1111;
        tick();
        bus.s0_ready = 1'b0;
        bus.s2_ready = 1'b1;
        bus.s2_rdata = 32'h2222_2222;
        tick();
        bus.s2_ready = 1'b0;
        bus.s1_ready = 1'b1;
        bus.s1_rdata = 32'h0000_00FF;
        tick();
        bus.s1_ready = 1'b0;
        bus.s1_rdata = 32'h0000_0BAD;
        wait_resp();
        tick();
        bus.m_valid = 1'b0;
        tick();

        // Unmapped address: error two cycles after the request edge.
        issue(32'h9000_0000, n);
        push(ERRD, 1'b1, n + 2);
        wait_resp();
        tick();
        bus.m_valid = 1'b0;
        tick();

        // I2C timeout after 8 BUSY cycles.
        issue(32'h5000_0004, n);
        push(ERRD, 1'b1, n + 9);
        wait_resp();
        tick();
        bus.m_valid = 1'b0;
        tick();

        // Ready on the 8th BUSY cycle beats the timeout.
        issue(32'h5000_0004, n);
        push(32'h0C0F_FEE0, 1'b0, n + 9);
        for (int i = 0; i < 8; i++) tick();
        bus.s2_ready = 1'b1;
        bus.s2_rdata = 32'h0C0F_FEE0;
        tick();
        bus.s2_ready = 1'b0;
        wait_resp();
        tick();
        bus.m_valid = 1'b0;
        tick();

        // Reset during BUSY clears all outputs without waiting for a clock edge.
        issue(32'h4000_0008, n);
        tick();
        tick();
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_ready", 64'(bus.m_ready), 64'd0);
        check("async_rst_m_err",   64'(bus.m_err),   64'd0);
        check("async_rst_m_rdata", 64'(bus.m_rdata), 64'd0);
        check("async_rst_busy",    64'(bus.busy),    64'd0);
        tick();
        bus.m_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        issue(32'h4000_000C, n);
        bus.s1_ready = 1'b1;
        bus.s1_rdata = 32'h1357_9BDF;
        push(32'h1357_9BDF, 1'b0, n + 2);
        wait_resp();
        tick();
        bus.s1_ready = 1'b0;
        bus.m_valid  = 1'b0;
        tick();

        // Back-to-back across slaves 0/1/2/unmapped, new request right after each m_ready.
        b2b_addr[0] = 32'h0000_0100; b2b_data[0] = 32'h1000_0001; b2b_err[0] = 1'b0;
        b2b_addr[1] = 32'h4000_0200; b2b_data[1] = 32'h2000_0002; b2b_err[1] = 1'b0;
        b2b_addr[2] = 32'h5000_0300; b2b_data[2] = 32'h3000_0003; b2b_err[2] = 1'b0;
        b2b_addr[3] = 32'hF000_0000; b2b_data[3] = ERRD;          b2b_err[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.s0_ready = (i == 0);
            bus.s1_ready = (i == 1);
            bus.s2_ready = (i == 2);
            bus.s0_rdata = b2b_data[0];
            bus.s1_rdata = b2b_data[1];
            bus.s2_rdata = b2b_data[2];
            issue(b2b_addr[i], n);
            push(b2b_data[i], b2b_err[i], n + 2);
            wait_resp();
            tick();
        end
        bus.s0_ready = 1'b0;
        bus.s1_ready = 1'b0;
        bus.s2_ready = 1'b0;
        bus.m_valid  = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
